// File: rtl/mm_pkg.sv
// Shared definitions for the matrix-multiply sequencer, MAC datapath and bench.
package mm_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        DRAIN = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } mm_state_e;

    localparam int DEF_ROWS   = 4;
    localparam int DEF_COLS   = 4;
    localparam int DEF_K      = 6;
    localparam int DEF_RD_LAT = 1;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mm_tag_pipe.sv
// Fixed-depth shift register that delays the accumulate tags to match the read latency.
module mm_tag_pipe #(
    parameter int DEPTH = 1,
    parameter int W     = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] tag_in,
    output logic [W-1:0] tag_out
);

    logic [W-1:0] stage_r [DEPTH];

    // Shift tags one stage per cycle; reset flushes every stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_r[i] <= '0;
            end
        end else begin
            stage_r[0] <= tag_in;
            for (int i = 1; i < DEPTH; i++) begin
                stage_r[i] <= stage_r[i-1];
            end
        end
    end

    assign tag_out = stage_r[DEPTH-1];

endmodule

// File: rtl/mm_seq_ctrl.sv
// Sequencer for P = X*A: issues operand reads, aligns MAC controls to read latency,
// writes each dot product to P and pulses done at the end of the run.
module mm_seq_ctrl
    import mm_pkg::*;
#(
    parameter int ROWS   = DEF_ROWS,
    parameter int COLS   = DEF_COLS,
    parameter int K      = DEF_K,
    parameter int RD_LAT = DEF_RD_LAT,
    parameter int X_AW   = 5,
    parameter int A_AW   = 5,
    parameter int P_AW   = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            Start,
    output logic            busy,
    output logic            done,
    output logic            rd_en,
    output logic [X_AW-1:0] addr_x,
    output logic [A_AW-1:0] addr_A,
    output logic            acc_en,
    output logic            acc_clr,
    output logic            wr_en,
    output logic [P_AW-1:0] addr_P
);

    localparam int RW   = cnt_w(K);
    localparam int ROWW = cnt_w(ROWS);
    localparam int COLW = cnt_w(COLS);
    localparam int DW   = cnt_w(RD_LAT);

    mm_state_e       state_r;
    logic [RW-1:0]   r_r;
    logic [ROWW-1:0] row_r;
    logic [COLW-1:0] col_r;
    logic [P_AW-1:0] nn_r;
    logic [DW-1:0]   dcnt_r;
    logic [X_AW-1:0] xbase_r;
    logic [1:0]      tag_in_s;
    logic [1:0]      tag_out_s;

    // Outputs are loaded on the edge that enters a state, so they are valid during it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            r_r     <= '0;
            row_r   <= '0;
            col_r   <= '0;
            nn_r    <= '0;
            dcnt_r  <= '0;
            xbase_r <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            rd_en   <= 1'b0;
            wr_en   <= 1'b0;
            addr_x  <= '0;
            addr_A  <= '0;
            addr_P  <= '0;
        end else begin
            rd_en  <= 1'b0;
            wr_en  <= 1'b0;
            done   <= 1'b0;
            addr_x <= '0;
            addr_A <= '0;
            addr_P <= '0;
            case (state_r)
                IDLE: begin
                    if (Start) begin
                        state_r <= ISSUE;
                        r_r     <= '0;
                        row_r   <= '0;
                        col_r   <= '0;
                        nn_r    <= '0;
                        xbase_r <= '0;
                        busy    <= 1'b1;
                        rd_en   <= 1'b1;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                ISSUE: begin
                    if (r_r == RW'(K - 1)) begin
                        r_r     <= '0;
                        dcnt_r  <= '0;
                        state_r <= DRAIN;
                    end else begin
                        r_r    <= r_r + RW'(1);
                        rd_en  <= 1'b1;
                        addr_x <= addr_x + X_AW'(1);
                        addr_A <= addr_A + A_AW'(COLS);
                    end
                end
                DRAIN: begin
                    if (dcnt_r == DW'(RD_LAT - 1)) begin
                        state_r <= WRITE;
                        wr_en   <= 1'b1;
                        addr_P  <= nn_r;
                    end else begin
                        dcnt_r <= dcnt_r + DW'(1);
                    end
                end
                WRITE: begin
                    if ((row_r == ROWW'(ROWS - 1)) && (col_r == COLW'(COLS - 1))) begin
                        state_r <= DONE;
                        done    <= 1'b1;
                    end else begin
                        state_r <= ISSUE;
                        rd_en   <= 1'b1;
                        nn_r    <= nn_r + P_AW'(1);
                        // Row base steps by K on column wrap; column start is just col.
                        if (col_r == COLW'(COLS - 1)) begin
                            col_r   <= '0;
                            row_r   <= row_r + ROWW'(1);
                            xbase_r <= xbase_r + X_AW'(K);
                            addr_x  <= xbase_r + X_AW'(K);
                            addr_A  <= '0;
                        end else begin
                            col_r  <= col_r + COLW'(1);
                            addr_x <= xbase_r;
                            addr_A <= A_AW'(col_r) + A_AW'(1);
                        end
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    // First term of each element is tagged so the MAC loads instead of accumulating.
    always_comb begin
        tag_in_s = {rd_en, rd_en && (r_r == '0)};
    end

    mm_tag_pipe #(
        .DEPTH (RD_LAT),
        .W     (2)
    ) u_tag_pipe (
        .clk     (clk),
        .rst     (rst),
        .tag_in  (tag_in_s),
        .tag_out (tag_out_s)
    );

    assign acc_en  = tag_out_s[1];
    assign acc_clr = tag_out_s[0];

endmodule

// File: tb/tb_mm_seq_ctrl.sv
// Self-checking bench: two sequencers (RD_LAT=1 and 3) against a timeline model and a MAC model.
module tb_mm_seq_ctrl;
    import mm_pkg::*;

    localparam int ROWS = DEF_ROWS;
    localparam int COLS = DEF_COLS;
    localparam int K    = DEF_K;
    localparam int NEL  = ROWS * COLS;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       rd_en;
        logic [4:0] ax;
        logic [4:0] aa;
        logic       acc_en;
        logic       acc_clr;
        logic       wr_en;
        logic [3:0] ap;
    } obs_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;

    logic a_busy, a_done, a_rd_en, a_acc_en, a_acc_clr, a_wr_en;
    logic [4:0] a_ax, a_aa;
    logic [3:0] a_ap;
    logic b_busy, b_done, b_rd_en, b_acc_en, b_acc_clr, b_wr_en;
    logic [4:0] b_ax, b_aa;
    logic [3:0] b_ap;

    mm_seq_ctrl #(.RD_LAT(1)) dut_a (
        .clk(clk), .rst(rst), .Start(start), .busy(a_busy), .done(a_done),
        .rd_en(a_rd_en), .addr_x(a_ax), .addr_A(a_aa), .acc_en(a_acc_en),
        .acc_clr(a_acc_clr), .wr_en(a_wr_en), .addr_P(a_ap)
    );

    mm_seq_ctrl #(.RD_LAT(3)) dut_b (
        .clk(clk), .rst(rst), .Start(start), .busy(b_busy), .done(b_done),
        .rd_en(b_rd_en), .addr_x(b_ax), .addr_A(b_aa), .acc_en(b_acc_en),
        .acc_clr(b_acc_clr), .wr_en(b_wr_en), .addr_P(b_ap)
    );

    always #5 clk = ~clk;

    int   nchk = 0;
    int   nerr = 0;
    int   cyc = 0;
    int   ta = 0;
    int   tb = 0;
    bit   armed = 1'b0;
    int   e_mark = 0;
    obs_t oa, ob;
    obs_t tr_a [256];
    obs_t tr_b [256];
    int   done_a [8] = '{default: 0};
    int   done_b [8] = '{default: 0};
    int   nda = 0;
    int   ndb = 0;
    int   bcnt_a = 0;
    int   wr_hist [64] = '{default: 0};
    int   nwr = 0;
    int   xm [24];
    int   am [24];
    int   pmem [16] = '{default: 0};
    int   prod_q = 0;
    int   acc = 0;

    int exp_ax0 [6] = '{0, 1, 2, 3, 4, 5};
    int exp_aa0 [6] = '{0, 4, 8, 12, 16, 20};
    int exp_ax5 [6] = '{6, 7, 8, 9, 10, 11};
    int exp_aa5 [6] = '{1, 5, 9, 13, 17, 21};

    task automatic check(input string name, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Expected outputs at cycle t of a run (t=0 idle, t=1 first issue), from the schedule alone.
    function automatic obs_t model(input int t, input int lat);
        obs_t o;
        int p, e, off;
        o = '0;
        p = K + lat + 1;
        if (t == 0) return o;
        o.busy = 1'b1;
        if (t == NEL * p + 1) begin
            o.done = 1'b1;
            return o;
        end
        e   = (t - 1) / p;
        off = (t - 1) % p;
        if (off < K) begin
            o.rd_en = 1'b1;
            o.ax    = 5'((e / COLS) * K + off);
            o.aa    = 5'(off * COLS + e % COLS);
        end
        if (off >= lat && off <= K - 1 + lat) begin
            o.acc_en  = 1'b1;
            o.acc_clr = (off == lat);
        end
        if (off == p - 1) begin
            o.wr_en = 1'b1;
            o.ap    = 4'(e);
        end
        return o;
    endfunction

    function automatic int next_t(input int t, input logic s, input int lat);
        if (t == 0) return s ? 1 : 0;
        if (t == NEL * (K + lat + 1) + 1) return 0;
        return t + 1;
    endfunction

    task automatic check_obs(input string name, input int t, input obs_t act, input obs_t exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s t=%0d cyc=%0d got %h expected %h", name, t, cyc, act, exp);
        end
    endtask

    // One clock: advance the model on the rising edge, compare and record on the falling edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            cyc++;
            if (rst) begin
                ta = 0;
                tb = 0;
                armed = 1'b1;
            end else begin
                ta = next_t(ta, start, 1);
                tb = next_t(tb, start, 3);
            end
            @(negedge clk);
            oa = {a_busy, a_done, a_rd_en, a_ax, a_aa, a_acc_en, a_acc_clr, a_wr_en, a_ap};
            ob = {b_busy, b_done, b_rd_en, b_ax, b_aa, b_acc_en, b_acc_clr, b_wr_en, b_ap};
            if (armed) begin
                check_obs("dut_a", ta, oa, model(ta, 1));
                check_obs("dut_b", tb, ob, model(tb, 3));
                if (ta < 256) tr_a[ta] = oa;
                if (tb < 256) tr_b[tb] = ob;
                if (oa.done) begin
                    if (nda < 8) done_a[nda] = cyc - e_mark;
                    nda++;
                end
                if (ob.done) begin
                    if (ndb < 8) done_b[ndb] = cyc - e_mark;
                    ndb++;
                end
                if (oa.busy) bcnt_a++;
                if (oa.acc_en) acc = oa.acc_clr ? prod_q : acc + prod_q;
                if (oa.wr_en) begin
                    pmem[oa.ap] = acc;
                    wr_hist[nwr % 64] = int'(oa.ap);
                    nwr++;
                end
                if (oa.rd_en && oa.ax < 24 && oa.aa < 24) prod_q = xm[oa.ax] * am[oa.aa];
            end
        end
    endtask

    initial begin
        int b_nda, b_ndb, b_bcnt, b_nwr, ref_p;

        for (int i = 0; i < 24; i++) begin
            xm[i] = int'($urandom_range(0, 255));
            am[i] = int'($urandom_range(0, 255));
        end

        // Reset with Start high: held off while rst is asserted.
        rst = 1'b1;
        start = 1'b1;
        step(2);
        check("reset_out_a", int'(oa), 0);
        check("reset_out_b", int'(ob), 0);

        // Single run, both latencies in parallel.
        rst = 1'b0;
        e_mark = cyc;
        b_nda = nda; b_ndb = ndb; b_bcnt = bcnt_a; b_nwr = nwr;
        step(1);
        start = 1'b0;
        step(172);
        for (int k = 0; k < 6; k++) begin
            check("e0_addr_x", int'(tr_a[1 + k].ax), exp_ax0[k]);
            check("e0_addr_A", int'(tr_a[1 + k].aa), exp_aa0[k]);
            check("e5_addr_x", int'(tr_a[41 + k].ax), exp_ax5[k]);
            check("e5_addr_A", int'(tr_a[41 + k].aa), exp_aa5[k]);
        end
        check("e0_acc_at_t1", int'(tr_a[1].acc_en), 0);
        check("e0_first_clr", int'({tr_a[2].acc_en, tr_a[2].acc_clr}), 3);
        check("e0_second_noclr", int'({tr_a[3].acc_en, tr_a[3].acc_clr}), 2);
        check("e0_wr_en", int'(tr_a[8].wr_en), 1);
        check("e0_addr_P", int'(tr_a[8].ap), 0);
        check("e5_wr_en", int'(tr_a[48].wr_en), 1);
        check("e5_addr_P", int'(tr_a[48].ap), 5);
        check("lat3_acc_t3", int'(tr_b[3].acc_en), 0);
        check("lat3_first_clr", int'({tr_b[4].acc_en, tr_b[4].acc_clr}), 3);
        check("lat3_wr_t10", int'({tr_b[10].wr_en, tr_b[10].ap}), 16);
        check("done_count_a", nda - b_nda, 1);
        check("done_cycle_a", done_a[b_nda], 129);
        check("done_cycle_b", done_b[b_ndb], 161);
        check("busy_cycles_a", bcnt_a - b_bcnt, 129);
        check("wr_count_a", nwr - b_nwr, 16);
        for (int k = 0; k < 16; k++) begin
            check("wr_order_a", wr_hist[(b_nwr + k) % 64], k);
        end
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                ref_p = 0;
                for (int k = 0; k < K; k++) ref_p += xm[r * K + k] * am[k * COLS + c];
                check("p_value", pmem[r * COLS + c], ref_p);
            end
        end

        // Start held high: no restart while busy, next run the cycle after done.
        start = 1'b1;
        e_mark = cyc;
        b_nda = nda; b_ndb = ndb;
        step(262);
        start = 1'b0;
        check("held_done1_a", done_a[b_nda], 129);
        check("held_done2_a", done_a[b_nda + 1], 259);
        check("held_done1_b", done_b[b_ndb], 161);

        // Reset from an arbitrary point, then reset mid-issue at r=3 of element 7.
        rst = 1'b1;
        step(2);
        check("rst_arb_a", int'(oa), 0);
        check("rst_arb_b", int'(ob), 0);
        rst = 1'b0;
        start = 1'b1;
        e_mark = cyc;
        step(1);
        start = 1'b0;
        check("first_issue_busy", int'({oa.busy, oa.rd_en, oa.ax, oa.aa}), 12'hC00);
        step(59);
        check("mid_issue_addr_x", int'(oa.ax), 9);
        check("mid_issue_addr_A", int'(oa.aa), 15);
        rst = 1'b1;
        step(1);
        check("mid_rst_out_a", int'(oa), 0);
        check("mid_rst_out_b", int'(ob), 0);
        step(1);
        rst = 1'b0;
        start = 1'b1;
        step(1);
        start = 1'b0;
        check("post_rst_start", int'({oa.busy, oa.rd_en}), 3);
        step(135);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/mm_seq_ctrl.md
# mm_seq_ctrl

Sequencer for the matrix-multiply datapath computing P = X·A, where X is ROWS×K, A is K×COLS and P is ROWS×COLS, stored row-major in three single-port memories. It issues operand reads, drives the MAC accumulator's clear and enable controls aligned to the memory read latency, and writes each finished dot product to the P memory. It then reports completion to the host with a one-cycle done pulse.

## Interface
- ROWS, 4, rows of X and P
- COLS, 4, columns of A and P
- K, 6, inner dimension (terms per dot product)
- RD_LAT, 1, X/A memory read latency in cycles (≥1)
- X_AW, 5, addr_x width (≥ clog2(ROWS·K))
- A_AW, 5, addr_A width (≥ clog2(K·COLS))
- P_AW, 4, addr_P width (≥ clog2(ROWS·COLS))
- clk  in  1  clock; one clock domain, rising edge
- rst  in  1  reset, synchronous, active-high
- Start  in  1  level; sampled only in IDLE
- busy  out  1  high from first ISSUE cycle through the DONE cycle
- done  out  1  one-cycle pulse when the run ends
- rd_en  out  1  X and A read strobe
- addr_x  out  X_AW  X address
- addr_A  out  A_AW  A address
- acc_en  out  1  MAC accumulate; rd_en delayed by RD_LAT
- acc_clr  out  1  with acc_en on the first term of each element: acc ← product
- wr_en  out  1  P write strobe
- addr_P  out  P_AW  P address

## Operation
- States: IDLE, ISSUE, DRAIN, WRITE, DONE. Counters: r (0..K-1), row (0..ROWS-1), col (0..COLS-1), nn = row·COLS+col, dcnt (0..RD_LAT-1).
- IDLE: when Start=1, go to ISSUE and clear r, row, col. Otherwise stay in IDLE.
- ISSUE: rd_en=1, addr_x = row·K + r, addr_A = r·COLS + col. Increment r. At r=K-1, clear r and dcnt and go to DRAIN.
- DRAIN: remain for RD_LAT cycles, then go to WRITE.
- WRITE: wr_en=1, addr_P=nn. If nn=ROWS·COLS-1, go to DONE. Otherwise advance col, wrap col into row, and go to ISSUE.
- DONE: done=1 and busy=1 for one cycle, then go to IDLE.
- Addresses are computed with multiply-free increments: addr_x steps by 1, and addr_A steps by COLS. Width is sufficient, so there is no truncation. In cycles where the strobes are 0, addr_x, addr_A and addr_P are 0.
- acc_en and acc_clr come from an RD_LAT-deep tag pipeline fed by rd_en and (rd_en && r==0).
- Start is ignored in every state except IDLE. A Start still high in the cycle after DONE begins a new run.
- rst: all state, counters and the tag pipeline clear in one cycle. The block returns to IDLE regardless of its current state.

## Timing
- All outputs are registered. After rst, every output is 0.
- Start sampled at edge E. The first ISSUE cycle, with rd_en, busy and addr 0, is E+1.
- Per element: K ISSUE cycles, RD_LAT DRAIN cycles and 1 WRITE cycle. Total per element is K+RD_LAT+1 cycles (8 with the default parameters).
- Last rd_en of an element occurs at cycle c. Its acc_en occurs at c+RD_LAT and wr_en at c+RD_LAT+1, when the accumulator holds the final sum.
- Full run: ROWS·COLS·(K+RD_LAT+1) busy cycles plus 1 DONE cycle. Defaults give 128 + 1; done goes high 129 cycles after E.
- rd_en and wr_en are never asserted in the same cycle. acc_en never overlaps wr_en.

## Structure
- Shared package mm_pkg holds the state enum (IDLE/ISSUE/DRAIN/WRITE/DONE) and the default ROWS, COLS, K and RD_LAT constants, which are shared with the MAC datapath and the testbench.
- Sub-module mm_tag_pipe is a parameterised RD_LAT-deep shift register carrying {acc_en, acc_clr}, cleared by rst.

## Test plan
- Reset: assert rst for 2 cycles from arbitrary state -> every output 0, state IDLE; Start is then accepted on the next cycle.
- Default params, single Start pulse -> element 0: addr_x 0..5, addr_A 0,4,8,12,16,20; acc_clr only with the first acc_en (1 cycle after the first rd_en); wr_en with addr_P=0 at the 8th cycle after ISSUE entry.
- Element nn=5 (row 1, col 1) -> addr_x 6..11, addr_A 1,5,9,13,17,21, then wr_en with addr_P=5.
- Full run with a reference-model MAC and random X/A -> exactly 16 wr_en with addr_P 0..15 ascending and correct P values; busy high 129 cycles; exactly one done pulse.
- Start held high throughout -> no restart during busy; a second run begins the cycle after DONE; rst asserted mid-ISSUE (r=3, nn=7) -> next cycle all outputs 0 and no stray acc_en.
- RD_LAT=3 -> 10 cycles per element, acc_en 3 cycles after rd_en, done at cycle 161.
